cache_mem_arbiter: RTL
======================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  ADDR_W, 64, address width.
  DATA_W, 512, cache-line data width.
  TAG_W, 64, tag word width.
  ID_W, 16, AXI ID width.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  clk  in  1  single clock, rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  rq0_valid_i / rq1_valid_i  in  1  requester k has a pending request.
  rq0_we_i / rq1_we_i  in  1  1 = line write, 0 = line read.
  rq0_addr_i / rq1_addr_i  in  ADDR_W  byte address.
  rq0_wdata_i / rq1_wdata_i  in  DATA_W  write line.
  rq0_ready_o / rq1_ready_o  out  1  one-cycle grant pulse; request is sampled this cycle.
  rq0_done_o / rq1_done_o  out  1  one-cycle completion pulse.
  rq_rdata_o  out  TAG_W+DATA_W  {tag, data} of the last completed read.
  arid_o  out  ID_W;  araddr_o  out  ADDR_W;  arvalid_o  out  1;  arready_i  in  1.
  rid_i  in  ID_W;  rdata_i  in  TAG_W+DATA_W;  rvalid_i  in  1;  rready_o  out  1.
  awid_o  out  ID_W;  awaddr_o  out  ADDR_W;  awvalid_o  out  1;  awready_i  in  1.
  wid_o  out  ID_W;  wdata_o  out  DATA_W;  wvalid_o  out  1;  wready_i  in  1.
  bid_i  in  ID_W;  bvalid_i  in  1;  bready_o  out  1.
  busy_o  out  1  high whenever state != S_IDLE.
  rd_cnt_o / wr_cnt_o  out  32  completed read / write counts.

Function
REQ-003 SHALL implement FSM states S_IDLE, S_AR, S_R, S_AWW and S_B, with at most one transaction outstanding.
REQ-004 In S_IDLE with any rqk_valid_i high, SHALL grant exactly one port; the grant is combinational that cycle: rqk_ready_o=1, and addr, we, wdata and port are latched.
REQ-005 Arbitration SHALL be round-robin on a last-grant pointer:
  - if only one port is valid, that port wins;
  - if both are valid, the port != last wins;
  - the pointer updates at grant.
REQ-006 After a grant, next state SHALL be S_AR if we=0 and S_AWW if we=1.
REQ-007 In S_AR, SHALL drive arvalid_o=1 with the latched address and hold it until arready_i; then go to S_R.
REQ-008 In S_R, SHALL drive rready_o=1; on rvalid_i:
  - register rdata_i into rq_rdata_o;
  - pulse rqk_done_o for one cycle on the next cycle;
  - increment rd_cnt_o;
  - return to S_IDLE.
REQ-009 In S_AWW, SHALL assert awvalid_o and wvalid_o together:
  - each is deasserted independently after its own handshake, tracked by aw_seen/w_seen flags;
  - when both handshakes are complete (including the same cycle), go to S_B.
REQ-010 In S_B, SHALL drive bready_o=1; on bvalid_i, pulse rqk_done_o next cycle, increment wr_cnt_o, and return to S_IDLE.
REQ-011 arid_o, awid_o and wid_o SHALL equal the granted port number zero-extended to ID_W.
REQ-012 rid_i and bid_i SHALL be ignored; responses always belong to the single outstanding transaction.
REQ-013 AXI address and data outputs SHALL be stable while their valid is high; arvalid_o, awvalid_o and wvalid_o SHALL never drop before their handshake.
REQ-014 rqk_valid_i changes outside the grant cycle SHALL have no effect on an in-flight transaction.
REQ-015 rq_rdata_o SHALL hold its value until the next read completion; write completions SHALL leave it unchanged.
REQ-016 A new grant in S_IDLE SHALL be permitted in the same cycle a done pulse is high; minimum spacing is one grant per 3 cycles for reads.
REQ-017 Counters SHALL wrap modulo 2^32 with no saturation.

Reset
REQ-018 On rst_n low, regardless of state and without waiting for a clock edge, the block SHALL enter S_IDLE with:
  - all valid, ready, done and busy outputs at 0;
  - counters at 0;
  - rq_rdata_o at 0;
  - last-grant pointer at 1, so port 0 wins the first tie.
REQ-019 A transaction interrupted by reset SHALL be abandoned, with no done pulse and no counter update.

Verification
REQ-020 Port 0 read of 0x0000_0000_0000_1040 with slave arready and rvalid after 1 cycle each -> araddr_o=0x1040, arid_o=0, rq0_done_o pulses once, rq_rdata_o equals the slave data, rd_cnt_o=1.
REQ-021 rq0 and rq1 both valid continuously for 4 transactions -> grants alternate 0,1,0,1; 4 done pulses in grant order.
REQ-022 Port 1 write with awready_i delayed 3 cycles after wready_i -> wvalid_o drops after the W handshake, awvalid_o holds until the AW handshake, S_B is reached, wr_cnt_o=1, awid_o=1.
REQ-023 rst_n asserted in S_R with rvalid_i pending -> outputs clear immediately, no done pulse, busy_o=0; after release, a fresh port 0 read completes normally.
REQ-024 Preload rd_cnt_o=0xFFFF_FFFF via force and complete one read -> rd_cnt_o=0.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Two-requester cache line arbiter onto a single AXI master port.
// Round-robin grant, one transaction in flight, read/write completion counters.
module cache_mem_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 512,
   parameter int TAG_W  = 64,
   parameter int ID_W   = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    rq0_valid_i,
   input  logic                    rq1_valid_i,
   input  logic                    rq0_we_i,
   input  logic                    rq1_we_i,
   input  logic [ADDR_W-1:0]       rq0_addr_i,
   input  logic [ADDR_W-1:0]       rq1_addr_i,
   input  logic [DATA_W-1:0]       rq0_wdata_i,
   input  logic [DATA_W-1:0]       rq1_wdata_i,
   output logic                    rq0_ready_o,
   output logic                    rq1_ready_o,
   output logic                    rq0_done_o,
   output logic                    rq1_done_o,
   output logic [TAG_W+DATA_W-1:0] rq_rdata_o,
   output logic [ID_W-1:0]         arid_o,
   output logic [ADDR_W-1:0]       araddr_o,
   output logic                    arvalid_o,
   input  logic                    arready_i,
   input  logic [ID_W-1:0]         rid_i,
   input  logic [TAG_W+DATA_W-1:0] rdata_i,
   input  logic                    rvalid_i,
   output logic                    rready_o,
   output logic [ID_W-1:0]         awid_o,
   output logic [ADDR_W-1:0]       awaddr_o,
   output logic                    awvalid_o,
   input  logic                    awready_i,
   output logic [ID_W-1:0]         wid_o,
   output logic [DATA_W-1:0]       wdata_o,
   output logic                    wvalid_o,
   input  logic                    wready_i,
   input  logic [ID_W-1:0]         bid_i,
   input  logic                    bvalid_i,
   output logic                    bready_o,
   output logic                    busy_o,
   output logic [31:0]             rd_cnt_o,
   output logic [31:0]             wr_cnt_o
);

   // state  | meaning
   // S_IDLE | no transaction; grant a requester if any is valid
   // S_AR   | read address phase, arvalid held until arready
   // S_R    | waiting for read data
   // S_AWW  | write address and data phases, each retired independently
   // S_B    | waiting for write response
   typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AWW, S_B} state_t;

   state_t                    r_state;
   logic                      r_last;
   logic                      r_port;
   logic [ADDR_W-1:0]         r_addr;
   logic [DATA_W-1:0]         r_wdata;
   logic                      r_aw_seen;
   logic                      r_w_seen;
   logic                      r_done0;
   logic                      r_done1;
   logic [TAG_W+DATA_W-1:0]   r_rdata;
   logic [31:0]               r_rd_cnt;
   logic [31:0]               r_wr_cnt;

   logic                      w_gnt;
   logic                      w_gnt_port;
   logic                      w_gnt_we;
   logic [ADDR_W-1:0]         w_gnt_addr;
   logic [DATA_W-1:0]         w_gnt_wdata;
   logic                      w_aw_hs;
   logic                      w_w_hs;
   logic                      w_unused_ids;

   // Response IDs carry no information with a single outstanding transaction.
   assign w_unused_ids = ^{rid_i, bid_i};

   // Tie goes to the port that did not win last; a lone request always wins.
   assign w_gnt       = rst_n && (r_state == S_IDLE) && (rq0_valid_i || rq1_valid_i);
   assign w_gnt_port  = (rq0_valid_i && rq1_valid_i) ? ~r_last : rq1_valid_i;
   assign w_gnt_we    = w_gnt_port ? rq1_we_i    : rq0_we_i;
   assign w_gnt_addr  = w_gnt_port ? rq1_addr_i  : rq0_addr_i;
   assign w_gnt_wdata = w_gnt_port ? rq1_wdata_i : rq0_wdata_i;

   assign rq0_ready_o = w_gnt && !w_gnt_port;
   assign rq1_ready_o = w_gnt &&  w_gnt_port;
   assign rq0_done_o  = r_done0;
   assign rq1_done_o  = r_done1;
   assign rq_rdata_o  = r_rdata;

   assign arvalid_o = (r_state == S_AR);
   assign rready_o  = (r_state == S_R);
   assign awvalid_o = (r_state == S_AWW) && !r_aw_seen;
   assign wvalid_o  = (r_state == S_AWW) && !r_w_seen;
   assign bready_o  = (r_state == S_B);
   assign busy_o    = (r_state != S_IDLE);

   assign w_aw_hs = awvalid_o && awready_i;
   assign w_w_hs  = wvalid_o  && wready_i;

   assign arid_o   = ID_W'(r_port);
   assign awid_o   = ID_W'(r_port);
   assign wid_o    = ID_W'(r_port);
   assign araddr_o = r_addr;
   assign awaddr_o = r_addr;
   assign wdata_o  = r_wdata;
   assign rd_cnt_o = r_rd_cnt;
   assign wr_cnt_o = r_wr_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_last    <= 1'b1;
         r_port    <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_aw_seen <= 1'b0;
         r_w_seen  <= 1'b0;
         r_done0   <= 1'b0;
         r_done1   <= 1'b0;
         r_rdata   <= '0;
         r_rd_cnt  <= '0;
         r_wr_cnt  <= '0;
      end else begin
         r_done0 <= 1'b0;
         r_done1 <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_gnt) begin
                  r_port    <= w_gnt_port;
                  r_last    <= w_gnt_port;
                  r_addr    <= w_gnt_addr;
                  r_wdata   <= w_gnt_wdata;
                  r_aw_seen <= 1'b0;
                  r_w_seen  <= 1'b0;
                  r_state   <= w_gnt_we ? S_AWW : S_AR;
               end
            end
            S_AR: begin
               if (arready_i) r_state <= S_R;
            end
            S_R: begin
               if (rvalid_i) begin
                  r_rdata  <= rdata_i;
                  r_rd_cnt <= r_rd_cnt + 32'd1;
                  r_done0  <= !r_port;
                  r_done1  <= r_port;
                  r_state  <= S_IDLE;
               end
            end
            S_AWW: begin
               if (w_aw_hs) r_aw_seen <= 1'b1;
               if (w_w_hs)  r_w_seen  <= 1'b1;
               // Both phases may retire in the same cycle.
               if ((r_aw_seen || w_aw_hs) && (r_w_seen || w_w_hs)) r_state <= S_B;
            end
            S_B: begin
               if (bvalid_i) begin
                  r_wr_cnt <= r_wr_cnt + 32'd1;
                  r_done0  <= !r_port;
                  r_done1  <= r_port;
                  r_state  <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
